// File: rtl/mic_clk_gen.sv
// mic_clk_gen: PDM microphone clock generator running on the PLL output clock.
// Waits for the (synchronised) PLL lock to stay high for SETTLE_CYC cycles, then
// divides clk down to a 50 % duty mic bit clock, gated per channel, with edge and
// frame strobes for the capture and decimation logic.
//
// Ports:
//   clk        PLL output clock, all state on its rising edge
//   rst_n      asynchronous active-low reset
//   pll_lock   raw PLL lock (asynchronous, synchronised here)
//   div_half   requested half-period in clk cycles (0 behaves as 1)
//   div_load   single-cycle request to adopt div_half
//   div_busy   a loaded divide value is waiting for a rising boundary
//   dec_ratio  mic clock periods per frame (0 behaves as 1)
//   ch_en      per-channel clock enable, sampled at rising boundaries
//   mic_clk    registered gated mic clocks
//   rise_stb   pulse in the cycle the mic clock goes high
//   fall_stb   pulse in the cycle the mic clock goes low
//   frame_stb  pulse with the first rise_stb of each frame
//   running    generator is producing clocks
module mic_clk_gen #(
    parameter int unsigned DIV_W        = 8,
    parameter int unsigned DEC_W        = 8,
    parameter int unsigned N_CH         = 4,
    parameter int unsigned SETTLE_CYC   = 1024,
    parameter int unsigned DEFAULT_HALF = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pll_lock,
    input  logic [DIV_W-1:0] div_half,
    input  logic             div_load,
    output logic             div_busy,
    input  logic [DEC_W-1:0] dec_ratio,
    input  logic [N_CH-1:0]  ch_en,
    output logic [N_CH-1:0]  mic_clk,
    output logic             rise_stb,
    output logic             fall_stb,
    output logic             frame_stb,
    output logic             running
);

    localparam int unsigned SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [DIV_W-1:0] RESET_HALF =
        (DEFAULT_HALF == 0) ? DIV_W'(1) : DIV_W'(DEFAULT_HALF);

    typedef enum logic [1:0] {StIdle, StSettle, StRun} state_e;

    state_e             state_q;
    logic               lock_meta_q;
    logic               lock_sync_q;
    logic [SET_W-1:0]   settle_cnt_q;
    logic [DIV_W-1:0]   half_cnt_q;
    logic [DIV_W-1:0]   cur_half_q;
    logic [DIV_W-1:0]   shadow_q;
    logic               phase_q;
    logic [N_CH-1:0]    ch_en_q;
    logic [DEC_W-1:0]   frame_cnt_q;
    logic [DEC_W-1:0]   dec_ratio_q;

    logic               half_tc;
    logic               frame_wrap;
    logic [DIV_W-1:0]   div_half_c;
    logic [DEC_W-1:0]   dec_ratio_c;

    always_comb begin
        half_tc     = (half_cnt_q == cur_half_q - DIV_W'(1));
        frame_wrap  = (frame_cnt_q == dec_ratio_q - DEC_W'(1));
        div_half_c  = (div_half == '0) ? DIV_W'(1) : div_half;
        dec_ratio_c = (dec_ratio == '0) ? DEC_W'(1) : dec_ratio;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            lock_meta_q  <= 1'b0;
            lock_sync_q  <= 1'b0;
            settle_cnt_q <= '0;
            half_cnt_q   <= '0;
            cur_half_q   <= RESET_HALF;
            shadow_q     <= RESET_HALF;
            phase_q      <= 1'b0;
            ch_en_q      <= '0;
            frame_cnt_q  <= '0;
            dec_ratio_q  <= DEC_W'(1);
            div_busy     <= 1'b0;
            mic_clk      <= '0;
            rise_stb     <= 1'b0;
            fall_stb     <= 1'b0;
            frame_stb    <= 1'b0;
            running      <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock;
            lock_sync_q <= lock_meta_q;
            rise_stb    <= 1'b0;
            fall_stb    <= 1'b0;
            frame_stb   <= 1'b0;

            // Capture is exclusive with apply below (needs busy low vs. busy high).
            if (div_load && !div_busy) begin
                shadow_q <= div_half_c;
                div_busy <= 1'b1;
            end

            case (state_q)
                StIdle, StSettle: begin
                    running     <= 1'b0;
                    mic_clk     <= '0;
                    phase_q     <= 1'b0;
                    half_cnt_q  <= '0;
                    frame_cnt_q <= '0;
                    // Counter held at 0 counts as a wrap, so the first frame uses
                    // the ratio presented while entering RUN.
                    dec_ratio_q <= dec_ratio_c;
                    // No clock to glitch outside RUN: apply a pending load at once.
                    if (div_busy) begin
                        cur_half_q <= shadow_q;
                        div_busy   <= 1'b0;
                    end
                    if (state_q == StIdle) begin
                        if (lock_sync_q) begin
                            settle_cnt_q <= '0;
                            state_q      <= StSettle;
                        end
                    end else if (!lock_sync_q) begin
                        state_q <= StIdle;
                    end else if (settle_cnt_q == SET_W'(SETTLE_CYC - 1)) begin
                        state_q <= StRun;
                        running <= 1'b1;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + SET_W'(1);
                    end
                end
                StRun: begin
                    if (!lock_sync_q) begin
                        // Lock loss beats any boundary in the same cycle.
                        state_q     <= StIdle;
                        running     <= 1'b0;
                        mic_clk     <= '0;
                        phase_q     <= 1'b0;
                        half_cnt_q  <= '0;
                        frame_cnt_q <= '0;
                    end else if (half_tc) begin
                        half_cnt_q <= '0;
                        phase_q    <= !phase_q;
                        if (!phase_q) begin
                            rise_stb  <= 1'b1;
                            ch_en_q   <= ch_en;
                            mic_clk   <= ch_en;
                            frame_stb <= (frame_cnt_q == '0);
                            if (frame_wrap) begin
                                frame_cnt_q <= '0;
                                dec_ratio_q <= dec_ratio_c;
                            end else begin
                                frame_cnt_q <= frame_cnt_q + DEC_W'(1);
                            end
                            // Only switch the divide at a low-to-high boundary so no
                            // half-period is ever partial.
                            if (div_busy) begin
                                cur_half_q <= shadow_q;
                                div_busy   <= 1'b0;
                            end
                        end else begin
                            fall_stb <= 1'b1;
                            mic_clk  <= '0;
                        end
                    end else begin
                        half_cnt_q <= half_cnt_q + DIV_W'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mic_clk_gen.sv
// Bench for mic_clk_gen: directed scenarios followed by random traffic, every
// output compared each cycle against an event-scheduled reference model.
module tb_mic_clk_gen;

    localparam int unsigned SETTLE = 16;
    localparam int unsigned DEF_HALF = 10;

    logic       clk;
    logic       rst_n;
    logic       pll_lock;
    logic [7:0] div_half;
    logic       div_load;
    logic       div_busy;
    logic [7:0] dec_ratio;
    logic [3:0] ch_en;
    logic [3:0] mic_clk;
    logic       rise_stb;
    logic       fall_stb;
    logic       frame_stb;
    logic       running;

    mic_clk_gen #(
        .DIV_W        (8),
        .DEC_W        (8),
        .N_CH         (4),
        .SETTLE_CYC   (SETTLE),
        .DEFAULT_HALF (DEF_HALF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pll_lock  (pll_lock),
        .div_half  (div_half),
        .div_load  (div_load),
        .div_busy  (div_busy),
        .dec_ratio (dec_ratio),
        .ch_en     (ch_en),
        .mic_clk   (mic_clk),
        .rise_stb  (rise_stb),
        .fall_stb  (fall_stb),
        .frame_stb (frame_stb),
        .running   (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_fail;

    // Reference model: lock history, absolute edge schedule and rise numbering.
    int       cyc;
    bit       m_s1, m_s2;
    int       streak;
    bit       m_run;
    bit       m_level;
    int       next_tog;
    int       m_cur;
    int       m_pend;
    bit       m_busy;
    bit [3:0] m_en;
    int       rise_k;
    int       frame_start;
    int       dec_len;
    bit       m_rise, m_fall, m_frame;
    bit [3:0] m_mic;
    int       lock_low;

    function automatic int clamp1(int v);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic model_reset();
        cyc = 0; m_s1 = 0; m_s2 = 0; streak = 0; m_run = 0; m_level = 0;
        next_tog = 0; m_cur = DEF_HALF; m_pend = DEF_HALF; m_busy = 0; m_en = '0;
        rise_k = 0; frame_start = 0; dec_len = 1;
        m_rise = 0; m_fall = 0; m_frame = 0; m_mic = '0;
    endtask

    task automatic model_edge();
        bit seen, was_run, old_busy, now_run;
        seen = m_s2;
        m_s2 = m_s1;
        m_s1 = pll_lock;
        was_run = m_run;
        old_busy = m_busy;
        m_rise = 0; m_fall = 0; m_frame = 0;
        streak = seen ? streak + 1 : 0;
        // Running once lock has been seen for the settle window plus the entry cycle.
        now_run = (streak >= int'(SETTLE) + 1);
        if (!was_run) begin
            if (old_busy) begin
                m_cur = m_pend;
                m_busy = 0;
            end
            dec_len = clamp1(int'(dec_ratio));
            frame_start = 0;
            rise_k = 0;
            m_level = 0;
            if (now_run) next_tog = cyc + m_cur;
        end else if (!now_run) begin
            m_level = 0;
        end else if (cyc == next_tog) begin
            m_level = !m_level;
            if (m_level) begin
                m_rise = 1;
                m_en = ch_en;
                m_frame = (rise_k == frame_start);
                if (rise_k == frame_start + dec_len - 1) begin
                    frame_start = rise_k + 1;
                    dec_len = clamp1(int'(dec_ratio));
                end
                rise_k++;
                if (old_busy) begin
                    m_cur = m_pend;
                    m_busy = 0;
                end
            end else begin
                m_fall = 1;
            end
            next_tog = cyc + m_cur;
        end
        if (div_load && !old_busy) begin
            m_pend = clamp1(int'(div_half));
            m_busy = 1;
        end
        m_run = now_run;
        m_mic = m_level ? m_en : 4'b0000;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_all();
        chk("running", 32'(running), 32'(m_run));
        chk("div_busy", 32'(div_busy), 32'(m_busy));
        chk("mic_clk", 32'(mic_clk), 32'(m_mic));
        chk("rise_stb", 32'(rise_stb), 32'(m_rise));
        chk("fall_stb", 32'(fall_stb), 32'(m_fall));
        chk("frame_stb", 32'(frame_stb), 32'(m_frame));
    endtask

    task automatic check_reset_values();
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_div_busy", 32'(div_busy), 32'd0);
        chk("rst_mic_clk", 32'(mic_clk), 32'd0);
        chk("rst_rise_stb", 32'(rise_stb), 32'd0);
        chk("rst_fall_stb", 32'(fall_stb), 32'd0);
        chk("rst_frame_stb", 32'(frame_stb), 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_level(input bit lvl);
        for (int i = 0; i < 600 && (m_level != lvl); i++) step();
    endtask

    task automatic load(input int val);
        div_half = 8'(val);
        div_load = 1'b1;
        step();
        div_load = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        lock_low = 0;
        model_reset();
        rst_n = 1'b0;
        pll_lock = 1'b0;
        div_half = 8'd10;
        div_load = 1'b0;
        dec_ratio = 8'd4;
        ch_en = 4'b1111;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values();
        rst_n = 1'b1;

        // Lock up, settle, first edges at the default divide; dec_ratio 4.
        pll_lock = 1'b1;
        run(90);

        // Load 5 mid-high, second load while busy must be ignored.
        wait_level(1'b1);
        run(3);
        load(5);
        load(7);
        run(50);

        // Decimation change mid-frame.
        run(7);
        dec_ratio = 8'd2;
        run(60);

        // Drop channel 2 mid-high, then re-enable.
        wait_level(1'b1);
        run(2);
        ch_en = 4'b1011;
        run(30);
        ch_en = 4'b1111;
        run(30);

        // Lock loss in RUN, then recovery through the full settle window.
        pll_lock = 1'b0;
        run(6);
        pll_lock = 1'b1;
        run(50);

        // Zero divide and zero ratio behave as 1.
        dec_ratio = 8'd0;
        load(0);
        run(40);

        // Load in the cycle of a rising boundary.
        load(3);
        run(10);
        wait_level(1'b0);
        for (int i = 0; i < 20 && !(m_level == 0 && cyc + 1 == next_tog); i++) step();
        load(2);
        run(20);

        // Random traffic with occasional lock loss and one async reset.
        for (int i = 0; i < 2500; i++) begin
            div_load = 1'b0;
            if ($urandom_range(0, 15) == 0) begin
                div_load = 1'b1;
                div_half = 8'($urandom_range(0, 6));
            end
            if ($urandom_range(0, 31) == 0) dec_ratio = 8'($urandom_range(0, 5));
            if ($urandom_range(0, 15) == 0) ch_en = 4'($urandom_range(0, 15));
            if (lock_low > 0) begin
                lock_low--;
                if (lock_low == 0) pll_lock = 1'b1;
            end else if ($urandom_range(0, 399) == 0) begin
                lock_low = $urandom_range(1, 5);
                pll_lock = 1'b0;
            end
            if (i == 1200) begin
                #3;
                rst_n = 1'b0;
                #1;
                check_reset_values();
                @(posedge clk);
                #1;
                check_reset_values();
                rst_n = 1'b1;
                model_reset();
            end
            step();
        end
        div_load = 1'b0;
        run(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
